enc16x4_queue: RTL and testbench
================================

# enc16x4_queue

Sequential 16-to-4 encoder: the sending-side counterpart of the 4x16 decoder. It captures event pulses on 16 one-hot request lines into a pending register and emits each pending line as a 4-bit binary index over a valid/ready handshake, highest index first, one index per accepted transfer. It sits between 16 event sources and any consumer that takes a binary index, e.g. a 4x16 decoder driving the select lines.

## Interface
- N, 16, number of request lines (fixed; width parameters exist for readability only)
- W, 4, index width, log2(N)
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  capture enable; 0 blocks new requests, draining continues
- req  in  16  request pulses; any number of bits may be high in a cycle
- idx  out  4  encoded index of the presented request
- valid  out  1  idx is valid
- ready  in  1  consumer accepts idx when valid && ready at a rising edge
- pend_cnt  out  5  number of set bits in pending register (0..16)
- any_pend  out  1  pending register nonzero, or valid high

## Operation
- Pending register pend[15:0]: each edge, pend <= (pend & ~clr) | (req & {16{en}}). Set wins over clear for the same bit.
- Output stage: register idx/valid. Stage is "loadable" when !valid, or valid && ready.
- When loadable and pend != 0: idx <= highest set bit index of pend, valid <= 1, and clr = one-hot of that bit; otherwise clr = 0.
- When loadable and pend == 0: valid <= 0, idx holds last value.
- When valid && !ready: idx and valid hold; pend still accumulates.
- A bit already in the output stage may be requested again; it re-enters pend as a new event. Duplicate pulses on a bit still pending merge into one.
- pend_cnt = popcount(pend), registered view of pend (same cycle as pend).
- any_pend = (pend != 0) | valid, combinational from registers.
- No overflow: at most 16 pending plus 1 presented.

## Timing
- Reset (rst high at an edge): pend = 0, valid = 0, idx = 0, pend_cnt = 0, any_pend = 0. Reset mid-transfer discards pending and presented requests; req in the reset cycle is ignored.
- Latency: req bit high at edge E0 (stage empty) -> pend bit set after E0 -> valid = 1 with its idx after E1. Two cycles request-to-valid.
- Throughput: with ready held high, one index per cycle back-to-back; no bubble between consecutive pending bits.
- After the last pop with pend == 0, valid drops after that same edge.
- Priority is recomputed at each load: a higher bit arriving while a lower one waits is emitted first. No fairness guarantee. Bit 0 can starve under continuous higher traffic. This behaviour is intended.
- en affects only capture at the edge it is sampled; in-flight and pending entries are unaffected.

## Structure
- Shared package: N = 16, W = 4, index type (4-bit), request vector type (16-bit).
- Sub-module prio_enc16x4: combinational highest-set-bit encoder, outputs idx[3:0] and nz. Built hierarchically from four 4-input priority stages plus one group-select stage. Mirrors the 2x4-based decoder tree.
- Top holds pend register, output stage, clr one-hot generation and popcount.

## Test plan
- Reset: drive req = 16'hFFFF with rst = 1 for 2 cycles, then release with req = 0 -> valid = 0, pend_cnt = 0 throughout and after.
- Single event: req = 16'h0020 for 1 cycle, ready = 1 -> valid high exactly 1 cycle, 2 edges later, idx = 5. pend_cnt goes 1 then 0.
- Burst, ready = 1: req = 16'h8421 for 1 cycle -> idx sequence 15, 10, 5, 0 on 4 consecutive cycles, then valid = 0.
- Backpressure: req = 16'h0003, ready = 0 for 5 cycles, then 1 -> idx = 1 held stable for 5 cycles, then idx = 0 for one cycle. pend_cnt = 1 while stalled.
- Set-wins-over-clear and re-request: pend = 16'h0010, ready = 1; pulse req = 16'h0010 in the load cycle -> idx = 4 emitted twice in consecutive cycles. en = 0 with req = 16'h0100 -> nothing emitted.
- Preemption: req = 16'h0001 and ready = 0, then req = 16'h4000 -> after ready rises, order is 0 (already presented), then 14.

Source files
------------

// File: rtl/enc16x4_pkg.sv
// enc16x4_pkg: shared widths, types and popcount helper for the 16-to-4 event encoder.
package enc16x4_pkg;
    localparam int N = 16;
    localparam int W = 4;

    typedef logic [W-1:0] idx_t;
    typedef logic [N-1:0] req_t;

    function automatic logic [W:0] popcount(input req_t v);
        logic [W:0] c;
        c = '0;
        for (int i = 0; i < N; i++) c += {{W{1'b0}}, v[i]};
        return c;
    endfunction
endpackage

// File: rtl/enc16x4_queue_prio.sv
// prio_enc16x4: combinational highest-set-bit encoder built from four 4-input stages
// and a group-select stage, mirroring the 2x4-based decoder tree.
module prio_enc16x4
    import enc16x4_pkg::*;
(
    input  req_t v_i,
    output idx_t idx_o,
    output logic nz_o
);
    logic [3:0] g_nz;
    logic [1:0] g_idx [4];
    logic [1:0] sel;

    for (genvar g = 0; g < 4; g++) begin : g_stage
        logic [3:0] s;
        assign s        = v_i[4*g +: 4];
        assign g_nz[g]  = |s;
        assign g_idx[g] = s[3] ? 2'd3 : s[2] ? 2'd2 : s[1] ? 2'd1 : 2'd0;
    end

    assign sel   = g_nz[3] ? 2'd3 : g_nz[2] ? 2'd2 : g_nz[1] ? 2'd1 : 2'd0;
    assign idx_o = {sel, g_idx[sel]};
    assign nz_o  = |g_nz;
endmodule

// File: rtl/enc16x4_queue.sv
// enc16x4_queue: captures one-hot event pulses into a pending register and drains
// them as binary indices over valid/ready, highest index first.
module enc16x4_queue
    import enc16x4_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  req_t       req,
    output idx_t       idx,
    output logic       valid,
    input  logic       ready,
    output logic [W:0] pend_cnt,
    output logic       any_pend
);
    req_t       pend_q, pend_d, clr;
    idx_t       idx_q, idx_d, top_idx;
    logic       valid_q, valid_d, top_nz, load;
    logic [W:0] cnt_q, cnt_d;

    prio_enc16x4 u_prio (.v_i(pend_q), .idx_o(top_idx), .nz_o(top_nz));

    // New requests are OR-ed in after the clear so a re-request of the popped bit survives.
    always_comb begin
        load    = !valid_q || ready;
        clr     = (load && top_nz) ? req_t'(1) << top_idx : '0;
        pend_d  = (pend_q & ~clr) | (req & {N{en}});
        valid_d = load ? top_nz : valid_q;
        idx_d   = (load && top_nz) ? top_idx : idx_q;
        cnt_d   = popcount(pend_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pend_q  <= pend_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign idx      = idx_q;
    assign valid    = valid_q;
    assign pend_cnt = cnt_q;
    assign any_pend = (|pend_q) | valid_q;
endmodule

// File: tb/tb_enc16x4_queue.sv
// tb_enc16x4_queue: directed scenarios with literal expectations plus randomized traffic,
// all checked every cycle against a set-of-pending-events model.
module tb_enc16x4_queue;
    import enc16x4_pkg::*;

    logic       clk = 1'b0;
    logic       rst, en, ready, valid, any_pend;
    req_t       req;
    idx_t       idx;
    logic [W:0] pend_cnt;

    int tests = 0;
    int fails = 0;

    bit [15:0] m_pend;
    bit        m_valid;
    int        m_idx;

    always #5 clk = ~clk;

    enc16x4_queue dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .idx(idx), .valid(valid),
        .ready(ready), .pend_cnt(pend_cnt), .any_pend(any_pend)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ones(input bit [15:0] v);
        int c = 0;
        for (int i = 0; i < 16; i++) c += int'(v[i]);
        return c;
    endfunction

    // Model: pending is a set of event bits; the presented slot takes the largest member.
    task automatic model_edge(input bit r, input bit e, input bit [15:0] q, input bit rd);
        int hi = -1;
        bit [15:0] np;
        if (r) begin
            m_pend  = '0;
            m_valid = 0;
            m_idx   = 0;
        end else begin
            np = m_pend;
            for (int i = 0; i < 16; i++) if (m_pend[i]) hi = i;
            if (!m_valid || rd) begin
                if (hi >= 0) begin
                    m_valid = 1;
                    m_idx   = hi;
                    np[hi]  = 0;
                end else m_valid = 0;
            end
            if (e) for (int i = 0; i < 16; i++) if (q[i]) np[i] = 1;
            m_pend = np;
        end
    endtask

    task automatic step(input logic r, input logic e, input req_t q, input logic rd);
        rst = r; en = e; req = q; ready = rd;
        @(posedge clk);
        model_edge(r, e, q, rd);
        #1;
        check("valid", valid, m_valid);
        check("idx", idx, m_idx);
        check("pend_cnt", pend_cnt, ones(m_pend));
        check("any_pend", any_pend, (m_pend != 0) || m_valid);
    endtask

    initial begin
        rst = 1; en = 1; req = '0; ready = 1;

        // reset with all requests high is ignored
        step(1, 1, 16'hFFFF, 1);
        step(1, 1, 16'hFFFF, 1);
        check("rst_valid", valid, 0);
        check("rst_cnt", pend_cnt, 0);
        check("rst_any", any_pend, 0);
        step(0, 1, 16'h0000, 1);
        check("rst_rel_cnt", pend_cnt, 0);
        check("rst_rel_valid", valid, 0);

        // single event
        step(0, 1, 16'h0020, 1);
        check("single_cnt1", pend_cnt, 1);
        check("single_v0", valid, 0);
        step(0, 1, 16'h0000, 1);
        check("single_v1", valid, 1);
        check("single_idx", idx, 5);
        check("single_cnt0", pend_cnt, 0);
        step(0, 1, 16'h0000, 1);
        check("single_vdrop", valid, 0);

        // burst drains highest first, back to back
        step(0, 1, 16'h8421, 1);
        check("burst_cnt", pend_cnt, 4);
        step(0, 1, 16'h0000, 1);
        check("burst_i0", idx, 15);
        check("burst_m0", m_idx, 15);
        step(0, 1, 16'h0000, 1);
        check("burst_i1", idx, 10);
        step(0, 1, 16'h0000, 1);
        check("burst_i2", idx, 5);
        step(0, 1, 16'h0000, 1);
        check("burst_i3", idx, 0);
        check("burst_v3", valid, 1);
        step(0, 1, 16'h0000, 1);
        check("burst_end", valid, 0);

        // backpressure
        step(0, 1, 16'h0003, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 16'h0000, 0);
            check("bp_idx", idx, 1);
            check("bp_valid", valid, 1);
            check("bp_cnt", pend_cnt, 1);
        end
        step(0, 1, 16'h0000, 1);
        check("bp_idx0", idx, 0);
        check("bp_valid0", valid, 1);
        step(0, 1, 16'h0000, 1);
        check("bp_end", valid, 0);

        // set wins over clear: re-request in the load cycle
        step(0, 1, 16'h0010, 1);
        step(0, 1, 16'h0010, 1);
        check("rereq_i0", idx, 4);
        check("rereq_cnt", pend_cnt, 1);
        step(0, 1, 16'h0000, 1);
        check("rereq_i1", idx, 4);
        check("rereq_v1", valid, 1);
        step(0, 1, 16'h0000, 1);
        check("rereq_end", valid, 0);
        step(0, 0, 16'h0100, 1);
        check("en0_cnt", pend_cnt, 0);
        step(0, 1, 16'h0000, 1);
        check("en0_valid", valid, 0);

        // preemption
        step(0, 1, 16'h0001, 0);
        step(0, 1, 16'h4000, 0);
        check("pre_i0", idx, 0);
        step(0, 1, 16'h0000, 0);
        check("pre_hold", idx, 0);
        step(0, 1, 16'h0000, 1);
        check("pre_i14", idx, 14);
        step(0, 1, 16'h0000, 1);
        check("pre_end", valid, 0);

        // randomized traffic with occasional reset
        for (int n = 0; n < 2000; n++) begin
            automatic req_t q = ($urandom_range(0, 2) == 0) ? req_t'($urandom) & req_t'($urandom) : '0;
            step($urandom_range(0, 99) == 0, $urandom_range(0, 4) != 0, q, $urandom_range(0, 2) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
